// File: rtl/reduction_mux_n_if.sv
// reduction_mux_n_if: bus bundle between the packet sources/sink and reduction_mux_n.
// The master side drives the input packets, stalls and config; the slave side is the mux.
interface reduction_mux_n_if #(
    parameter int NumPorts   = 7,
    parameter int DataWidth  = 256,
    parameter int IndexWidth = 8,
    parameter int CountWidth = 3
);
    logic [NumPorts*DataWidth-1:0] in_data;
    logic [NumPorts-1:0]           in_pipeline_stall;
    logic [NumPorts-1:0]           in_avail;
    logic                          out_stall;
    logic [DataWidth-1:0]          out;
    logic                          send;
    logic                          cfg_we;
    logic [IndexWidth-1:0]         cfg_index;
    logic [CountWidth-1:0]         cfg_expect;

    modport master (
        output in_data, in_pipeline_stall, out_stall, cfg_we, cfg_index, cfg_expect,
        input  in_avail, out, send
    );

    modport slave (
        input  in_data, in_pipeline_stall, out_stall, cfg_we, cfg_index, cfg_expect,
        output in_avail, out, send
    );
endinterface

// File: rtl/reduction_mux_n.sv
// reduction_mux_n: N-input output mux with per-input FIFOs, priority/round-robin
// arbitration and an in-network reduction table. Three-stage pipeline:
// FR (arbitrate + pop), RR (register packet + table read), WB (combine + out).
module reduction_mux_n #(
    parameter int NumPorts        = 7,
    parameter int DataWidth       = 256,
    parameter int FIFODepth       = 4,
    parameter int PriorityPos     = 152,
    parameter int PriorityWidth   = 8,
    parameter int ReductionBitPos = 254,
    parameter int IndexPos        = 128,
    parameter int IndexWidth      = 8,
    parameter int WeightPos       = 144,
    parameter int WeightWidth     = 8,
    parameter int PayloadLen      = 128,
    parameter int CountWidth      = 3
) (
    input  logic             clk,
    input  logic             rst,
    reduction_mux_n_if.slave bus
);

    localparam int AddrW      = $clog2(FIFODepth);
    localparam int PortW      = $clog2(NumPorts);
    localparam int TableDepth = 1 << IndexWidth;

    // Per-port FIFO view
    logic [NumPorts-1:0]                push_s;
    logic [NumPorts-1:0]                pop_s;
    logic [NumPorts-1:0]                nonempty_s;
    logic [NumPorts-1:0]                full_s;
    logic [NumPorts-1:0][DataWidth-1:0] head_s;

    // Arbitration
    logic                     grant_valid_s;
    logic [PortW-1:0]         grant_idx_s;
    logic [PortW-1:0]         rr_ptr_q;
    logic [PortW-1:0]         rr_ptr_d;
    logic [PortW-1:0]         cand_s;
    logic [PortW:0]           cand_raw_s;
    logic [PriorityWidth-1:0] best_prio_s;

    // Pipeline stages
    logic                   s1_valid_q;
    logic [DataWidth-1:0]   s1_pkt_q;
    logic                   s2_valid_q;
    logic [DataWidth-1:0]   s2_pkt_q;
    logic [CountWidth-1:0]  s2_arr_q;
    logic [CountWidth-1:0]  s2_exp_q;
    logic [WeightWidth-1:0] s2_w_q;
    logic [PayloadLen-1:0]  s2_pay_q;
    logic [DataWidth-1:0]   out_q;
    logic [DataWidth-1:0]   out_d;

    // Reduction table and expect-count array
    logic [CountWidth-1:0]  arr_q [TableDepth];
    logic [WeightWidth-1:0] w_q   [TableDepth];
    logic [PayloadLen-1:0]  pay_q [TableDepth];
    logic [CountWidth-1:0]  exp_q [TableDepth];

    // Table read (RR) and combine/write-back (WB)
    logic [IndexWidth-1:0]  rd_idx_s;
    logic [IndexWidth-1:0]  wr_idx_s;
    logic [CountWidth-1:0]  rd_arr_s;
    logic [CountWidth-1:0]  rd_exp_s;
    logic [WeightWidth-1:0] rd_w_s;
    logic [PayloadLen-1:0]  rd_pay_s;
    logic                   tbl_we_s;
    logic                   is_red_s;
    logic                   complete_s;
    logic [CountWidth-1:0]  arr_new_s;
    logic [CountWidth-1:0]  exp_eff_s;
    logic [WeightWidth-1:0] w_new_s;
    logic [PayloadLen-1:0]  pay_new_s;
    logic [CountWidth-1:0]  arr_wd_s;
    logic [WeightWidth-1:0] w_wd_s;
    logic [PayloadLen-1:0]  pay_wd_s;
    logic [DataWidth-1:0]   merged_s;

    for (genvar p = 0; p < NumPorts; p++) begin : g_fifo
        logic [DataWidth-1:0] mem_q [FIFODepth];
        logic [AddrW-1:0]     rd_ptr_q;
        logic [AddrW-1:0]     wr_ptr_q;
        logic [AddrW:0]       cnt_q;
        logic [AddrW:0]       cnt_d;
        logic                 full_q;
        logic [DataWidth-1:0] pkt_in_s;

        assign pkt_in_s      = bus.in_data[p*DataWidth +: DataWidth];
        // A full FIFO still accepts a push in the cycle it is being popped.
        assign push_s[p]     = ~bus.in_pipeline_stall[p] & pkt_in_s[DataWidth-1] & (~full_q | pop_s[p]);
        assign head_s[p]     = mem_q[rd_ptr_q];
        assign nonempty_s[p] = (cnt_q != '0);
        assign full_s[p]     = full_q;

        // Next occupancy from this cycle's push/pop pair.
        always_comb begin
            cnt_d = cnt_q;
            case ({push_s[p], pop_s[p]})
                2'b10:   cnt_d = cnt_q + (AddrW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AddrW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        // Pointers, occupancy and the registered full flag.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
                full_q   <= 1'b0;
            end else begin
                if (push_s[p]) wr_ptr_q <= wr_ptr_q + AddrW'(1);
                if (pop_s[p])  rd_ptr_q <= rd_ptr_q + AddrW'(1);
                cnt_q  <= cnt_d;
                full_q <= (cnt_d == (AddrW+1)'(FIFODepth));
            end
        end

        // Packet storage; contents are don't-care until pushed.
        always_ff @(posedge clk) begin
            if (push_s[p]) mem_q[wr_ptr_q] <= pkt_in_s;
        end
    end

    assign bus.in_avail = ~full_s;
    assign bus.out      = out_q;
    assign bus.send     = out_q[DataWidth-1];

    // Scan ports starting at rr_ptr; strict '>' keeps the first port on priority ties.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        best_prio_s   = '0;
        cand_raw_s    = '0;
        cand_s        = '0;
        for (int k = 0; k < NumPorts; k++) begin
            cand_raw_s = {1'b0, rr_ptr_q} + (PortW+1)'(k);
            cand_raw_s = (cand_raw_s >= (PortW+1)'(NumPorts)) ? cand_raw_s - (PortW+1)'(NumPorts) : cand_raw_s;
            cand_s     = cand_raw_s[PortW-1:0];
            if (nonempty_s[cand_s] &&
                (!grant_valid_s || (head_s[cand_s][PriorityPos +: PriorityWidth] > best_prio_s))) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = cand_s;
                best_prio_s   = head_s[cand_s][PriorityPos +: PriorityWidth];
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
        rr_ptr_d = (grant_idx_s == PortW'(NumPorts - 1)) ? '0 : grant_idx_s + PortW'(1);
    end

    // Pop only the granted FIFO, and nothing while the output is stalled.
    always_comb begin
        pop_s = '0;
        if (grant_valid_s && !bus.out_stall) begin
            pop_s[grant_idx_s] = 1'b1;
        end else begin
            pop_s = '0;
        end
    end

    // WB: accumulate reduction packets and build the next output word.
    always_comb begin
        is_red_s   = s2_pkt_q[ReductionBitPos];
        wr_idx_s   = s2_pkt_q[IndexPos +: IndexWidth];
        arr_new_s  = s2_arr_q + CountWidth'(1);
        w_new_s    = s2_w_q + s2_pkt_q[WeightPos +: WeightWidth];
        pay_new_s  = s2_pay_q + s2_pkt_q[PayloadLen-1:0];
        exp_eff_s  = (s2_exp_q == '0) ? CountWidth'(1) : s2_exp_q;
        complete_s = (arr_new_s >= exp_eff_s);
        merged_s   = s2_pkt_q;
        merged_s[WeightPos +: WeightWidth] = w_new_s;
        merged_s[PayloadLen-1:0]           = pay_new_s;
        tbl_we_s   = s2_valid_q && is_red_s && !bus.out_stall;
        arr_wd_s   = '0;
        w_wd_s     = '0;
        pay_wd_s   = '0;
        out_d      = '0;
        if (!s2_valid_q) begin
            out_d = '0;
        end else if (!is_red_s) begin
            out_d = s2_pkt_q;
        end else if (complete_s) begin
            out_d = merged_s;
        end else begin
            arr_wd_s = arr_new_s;
            w_wd_s   = w_new_s;
            pay_wd_s = pay_new_s;
            out_d    = '0;
        end
    end

    // RR: table read, forwarding the WB write when both touch the same index.
    always_comb begin
        rd_idx_s = s1_pkt_q[IndexPos +: IndexWidth];
        rd_exp_s = exp_q[rd_idx_s];
        if (tbl_we_s && (wr_idx_s == rd_idx_s)) begin
            rd_arr_s = arr_wd_s;
            rd_w_s   = w_wd_s;
            rd_pay_s = pay_wd_s;
        end else begin
            rd_arr_s = arr_q[rd_idx_s];
            rd_w_s   = w_q[rd_idx_s];
            rd_pay_s = pay_q[rd_idx_s];
        end
    end

    // Pipeline registers; out_stall freezes every stage and the RR pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_pkt_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_pkt_q   <= '0;
            s2_arr_q   <= '0;
            s2_exp_q   <= '0;
            s2_w_q     <= '0;
            s2_pay_q   <= '0;
            out_q      <= '0;
        end else if (!bus.out_stall) begin
            if (grant_valid_s) rr_ptr_q <= rr_ptr_d;
            s1_valid_q <= grant_valid_s;
            s1_pkt_q   <= head_s[grant_idx_s];
            s2_valid_q <= s1_valid_q;
            s2_pkt_q   <= s1_pkt_q;
            s2_arr_q   <= rd_arr_s;
            s2_exp_q   <= rd_exp_s;
            s2_w_q     <= rd_w_s;
            s2_pay_q   <= rd_pay_s;
            out_q      <= out_d;
        end
    end

    // Accumulator table: partial sums, cleared when a reduction completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TableDepth; i++) begin
                arr_q[i] <= '0;
                w_q[i]   <= '0;
                pay_q[i] <= '0;
            end
        end else if (tbl_we_s) begin
            arr_q[wr_idx_s] <= arr_wd_s;
            w_q[wr_idx_s]   <= w_wd_s;
            pay_q[wr_idx_s] <= pay_wd_s;
        end
    end

    // Expect-count array, written only by the config port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TableDepth; i++) exp_q[i] <= '0;
        end else if (bus.cfg_we) begin
            exp_q[bus.cfg_index] <= bus.cfg_expect;
        end
    end

endmodule

// File: tb/tb_reduction_mux_n.sv
// tb_reduction_mux_n: directed checks of pass-through, arbitration, reduction,
// forwarding, wrap-around, backpressure and reset for reduction_mux_n.
module tb_reduction_mux_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [7:0]   got[$];
    logic [255:0] pa, pb, pc;

    reduction_mux_n_if #(.NumPorts(7), .DataWidth(256), .IndexWidth(8), .CountWidth(3)) bus ();

    reduction_mux_n dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [255:0] mk_pkt(input logic [7:0] prio, input logic red,
                                            input logic [7:0] idx, input logic [7:0] wt,
                                            input logic [127:0] pay);
        logic [255:0] p;
        p = '0;
        p[255]      = 1'b1;
        p[254]      = red;
        p[152 +: 8] = prio;
        p[128 +: 8] = idx;
        p[144 +: 8] = wt;
        p[127:0]    = pay;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step_chk(input string tag, input logic [255:0] exp);
        @(negedge clk);
        chk(tag, {bus.send, bus.out}, {exp[255], exp});
    endtask

    task automatic quiet();
        bus.in_data           = '0;
        bus.in_pipeline_stall = '1;
    endtask

    task automatic set_port(input int p, input logic [255:0] pkt);
        bus.in_data[p*256 +: 256] = pkt;
        bus.in_pipeline_stall[p]  = 1'b0;
    endtask

    task automatic push_one(input int p, input logic [255:0] pkt);
        set_port(p, pkt);
        @(negedge clk);
        quiet();
    endtask

    task automatic cfg(input logic [7:0] idx, input logic [2:0] e);
        bus.cfg_we = 1'b1; bus.cfg_index = idx; bus.cfg_expect = e;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        quiet();
        bus.out_stall = 1'b0; bus.cfg_we = 1'b0; bus.cfg_index = '0; bus.cfg_expect = '0;

        // Reset state
        @(negedge clk);
        chk("reset_out", {bus.send, bus.out}, 257'(0));
        chk("reset_avail", 257'(bus.in_avail), 257'(7'h7F));
        rst = 1'b0;

        // Pass-through: priority 5 on port 3, visible three edges after the FIFO head
        pa = mk_pkt(8'd5, 1'b0, 8'h00, 8'h00, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        push_one(3, pa);
        step_chk("pass_c1", '0);
        step_chk("pass_c2", '0);
        step_chk("pass_c3", pa);
        step_chk("pass_after", '0);

        // Priority/RR: fill ports 0,1,2,4 while stalled, then drain
        do_reset();
        bus.out_stall = 1'b1;
        for (int s = 0; s < 4; s++) begin
            set_port(0, mk_pkt(8'd3, 1'b0, 8'h00, 8'h00, 128'(0 * 16 + s)));
            set_port(1, mk_pkt(8'd9, 1'b0, 8'h00, 8'h00, 128'(1 * 16 + s)));
            set_port(2, mk_pkt(8'd9, 1'b0, 8'h00, 8'h00, 128'(2 * 16 + s)));
            set_port(4, mk_pkt(8'd9, 1'b0, 8'h00, 8'h00, 128'(4 * 16 + s)));
            @(negedge clk);
        end
        quiet();
        chk("rr_avail_full", 257'(bus.in_avail), 257'(7'b1101000));
        bus.out_stall = 1'b0;
        got.delete();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bus.send) got.push_back(bus.out[7:0]);
        end
        chk("rr_count", 257'(got.size()), 257'(16));
        for (int i = 0; i < 16; i++) begin
            logic [7:0] e;
            logic [7:0] g;
            if (i < 12) e = 8'((i % 3 == 0 ? 1 : (i % 3 == 1 ? 2 : 4)) * 16 + i / 3);
            else        e = 8'(i - 12);
            g = (i < got.size()) ? got[i] : 8'hFF;
            chk($sformatf("rr_order_%0d", i), 257'(g), 257'(e));
        end

        // Reduction: expect 3 at 0x12, weights 1,2,3 payloads 10,20,30
        cfg(8'h12, 3'd3);
        set_port(0, mk_pkt(8'd1, 1'b1, 8'h12, 8'd1, 128'd10));
        set_port(5, mk_pkt(8'd1, 1'b1, 8'h12, 8'd2, 128'd20));
        set_port(6, mk_pkt(8'd1, 1'b1, 8'h12, 8'd3, 128'd30));
        @(negedge clk);
        quiet();
        step_chk("red_c1", '0);
        step_chk("red_c2", '0);
        step_chk("red_first", '0);
        step_chk("red_second", '0);
        step_chk("red_result", mk_pkt(8'd1, 1'b1, 8'h12, 8'd6, 128'd60));
        step_chk("red_after", '0);

        // Bypass: same packets back-to-back through one FIFO; also proves the entry was cleared
        push_one(2, mk_pkt(8'd1, 1'b1, 8'h12, 8'd1, 128'd10));
        push_one(2, mk_pkt(8'd1, 1'b1, 8'h12, 8'd2, 128'd20));
        push_one(2, mk_pkt(8'd1, 1'b1, 8'h12, 8'd3, 128'd30));
        step_chk("byp_first", '0);
        step_chk("byp_second", '0);
        step_chk("byp_result", mk_pkt(8'd1, 1'b1, 8'h12, 8'd6, 128'd60));
        step_chk("byp_after", '0);

        // Wrap: expect 2, payload and weight sums overflow
        cfg(8'h33, 3'd2);
        set_port(1, mk_pkt(8'd4, 1'b1, 8'h33, 8'hFF, {128{1'b1}}));
        set_port(3, mk_pkt(8'd4, 1'b1, 8'h33, 8'h02, 128'd2));
        @(negedge clk);
        quiet();
        step_chk("wrap_c1", '0);
        step_chk("wrap_c2", '0);
        step_chk("wrap_first", '0);
        step_chk("wrap_result", mk_pkt(8'd4, 1'b1, 8'h33, 8'h01, 128'd1));
        step_chk("wrap_after", '0);

        // Stall: A,B,C in flight, stall 5 cycles while D..G fill port 5
        pa = mk_pkt(8'd0, 1'b0, 8'h00, 8'h00, 128'hA);
        push_one(5, pa);
        push_one(5, mk_pkt(8'd0, 1'b0, 8'h00, 8'h00, 128'hB));
        push_one(5, mk_pkt(8'd0, 1'b0, 8'h00, 8'h00, 128'hC));
        step_chk("stall_pre", pa);
        bus.out_stall = 1'b1;
        push_one(5, mk_pkt(8'd0, 1'b0, 8'h00, 8'h00, 128'hD));
        chk("stall_hold_1", {bus.send, bus.out}, {1'b1, pa});
        chk("stall_avail_1", 257'(bus.in_avail), 257'(7'h7F));
        push_one(5, mk_pkt(8'd0, 1'b0, 8'h00, 8'h00, 128'hE));
        chk("stall_hold_2", {bus.send, bus.out}, {1'b1, pa});
        push_one(5, mk_pkt(8'd0, 1'b0, 8'h00, 8'h00, 128'hF));
        chk("stall_hold_3", {bus.send, bus.out}, {1'b1, pa});
        push_one(5, mk_pkt(8'd0, 1'b0, 8'h00, 8'h00, 128'h10));
        chk("stall_hold_4", {bus.send, bus.out}, {1'b1, pa});
        chk("stall_avail_full", 257'(bus.in_avail), 257'(7'b1011111));
        step_chk("stall_hold_5", pa);
        bus.out_stall = 1'b0;
        step_chk("rel_B", mk_pkt(8'd0, 1'b0, 8'h00, 8'h00, 128'hB));
        step_chk("rel_C", mk_pkt(8'd0, 1'b0, 8'h00, 8'h00, 128'hC));
        step_chk("rel_D", mk_pkt(8'd0, 1'b0, 8'h00, 8'h00, 128'hD));
        step_chk("rel_E", mk_pkt(8'd0, 1'b0, 8'h00, 8'h00, 128'hE));
        step_chk("rel_F", mk_pkt(8'd0, 1'b0, 8'h00, 8'h00, 128'hF));
        step_chk("rel_G", mk_pkt(8'd0, 1'b0, 8'h00, 8'h00, 128'h10));
        step_chk("rel_idle", '0);

        // Reset mid-reduction: two of three arrivals accumulated, then reset
        cfg(8'h40, 3'd3);
        pc = mk_pkt(8'd1, 1'b0, 8'h00, 8'h00, 128'h5A5A);
        set_port(0, mk_pkt(8'd2, 1'b1, 8'h40, 8'd5, 128'd7));
        set_port(1, mk_pkt(8'd2, 1'b1, 8'h40, 8'd5, 128'd7));
        set_port(2, pc);
        @(negedge clk);
        quiet();
        step_chk("rst_c1", '0);
        step_chk("rst_c2", '0);
        step_chk("rst_part1", '0);
        step_chk("rst_part2", '0);
        step_chk("rst_pass", pc);
        rst = 1'b1;
        #1;
        chk("rst_out_cleared", {bus.send, bus.out}, 257'(0));
        @(negedge clk);
        rst = 1'b0;
        // Cleared expect entry behaves as 1; a surviving partial sum would show up here
        pb = mk_pkt(8'd2, 1'b1, 8'h40, 8'd5, 128'd7);
        push_one(4, pb);
        step_chk("post_rst_c1", '0);
        step_chk("post_rst_c2", '0);
        step_chk("post_rst_single", pb);
        step_chk("post_rst_idle", '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reduction_mux_n.md
Name: reduction_mux_n

Overview:
- Parametrised N-input crossbar output mux with in-network reduction; successor to the fixed 7-port switch mux.
- Buffers each input in a FIFO and grants the highest-priority head, breaking ties round-robin.
- Non-reduction packets pass through. Reduction packets accumulate into a per-index table and emit one combined packet once the programmed expect count is reached.
- Adds output backpressure, empty-FIFO gating, read-after-write bypass and a runtime expect-count config port.

Parameters:
NumPorts, 7, input channel count (2..16)
DataWidth, 256, packet width; bit DataWidth-1 is the valid bit
FIFODepth, 4, per-input FIFO depth (power of 2)
PriorityPos, 152, LSB of the priority field
PriorityWidth, 8, priority field width
ReductionBitPos, 254, reduction-packet flag bit
IndexPos, 128, LSB of the table index field
IndexWidth, 8, table index width; table depth 2**IndexWidth
WeightPos, 144, LSB of the weight field
WeightWidth, 8, weight field width
PayloadLen, 128, payload bits [PayloadLen-1:0]
CountWidth, 3, expect/arrival counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_data  in  NumPorts*DataWidth  port p at [p*DataWidth +: DataWidth]
in_pipeline_stall  in  NumPorts  upstream stall; push only when low and the valid bit is set
in_avail  out  NumPorts  ~FIFO full, per port
out_stall  in  1  downstream backpressure
out  out  DataWidth  output packet register
send  out  1  out[DataWidth-1]
cfg_we  in  1  expect-count write strobe
cfg_index  in  IndexWidth  entry to program
cfg_expect  in  CountWidth  expected arrivals per reduction

Behaviour:
- Async reset clears:
  - all FIFOs, stage valids, the RR pointer and out (send=0);
  - every arrival counter, weight accumulator and payload accumulator;
  - every expect entry to 0.
- Stage 1 (FR), arbitration:
  - Only non-empty FIFOs compete; the largest priority wins.
  - Ties go to the first competing port at or after rr_ptr, cyclically.
  - On a grant: pop exactly that FIFO, register the head, set rr_ptr = winner+1 mod NumPorts.
  - If no FIFO is non-empty: no pop, stage valid=0.
- Stage 2 (RR): register the packet; for reduction packets, read the acc entry and the expect entry at its index.
- Stage 3 (WB):
  - Non-reduction: out <= packet.
  - Reduction: arr' = arr+1; w' = w + weight (mod 2**WeightWidth); pay' = pay + payload (mod 2**PayloadLen, single unsigned add).
  - Completion condition: arr' >= max(expect,1). Expect 0 behaves as 1.
  - Complete: out <= arriving packet with the weight field replaced by w' and the payload by pay'. Entry writes arr=0, w=0, pay=0.
  - Not complete: entry writes arr', w', pay'; out <= 0.
  - Invalid stage: out <= 0.
- Latency: FIFO head to out is 3 cycles with no stall. Sustains 1 packet/cycle.
- Bypass:
  - An S2 read whose index matches the S3 write in the same cycle uses the S3 write value, not the stale array.
  - Back-to-back same-index packets must accumulate exactly.
- out_stall=1 freezes the whole pipeline: no pop, stage registers hold, out holds, no table write. The held packet stays valid and is presented again.
- FIFO ordering:
  - Push when the FIFO is full is dropped (the upstream honours in_avail).
  - Push and pop in the same cycle on a full FIFO are both accepted.
  - in_avail reflects the registered full flag.
- Config:
  - cfg_we writes the separate expect array, which has no conflict with accumulator writes.
  - A write takes effect for packets reaching S2 on the next cycle or later.
  - Reprogramming an entry mid-reduction keeps its partial accumulation.
- Counter wrap: arr' overflowing CountWidth is impossible when expect <= 2**CountWidth-1. Expect must not exceed that.
- Reset asserted mid-operation discards in-flight packets and partial sums immediately.

Test Plan:
- Pass-through: one non-reduction packet with priority 5 on port 3, no stall -> appears on out exactly 3 cycles after the FIFO head, bit-identical, send=1 for one cycle.
- Priority/RR: ports 1,2,4 each hold 4 packets at priority 9, port 0 holds 4 at priority 3 -> grants 1,2,4 repeating until those FIFOs drain, then port 0; no empty FIFO is ever popped.
- Reduction:
  - Setup: cfg expect=3 at index 0x12; three reduction packets on ports 0,5,6 with weights 1,2,3 and payloads 10,20,30.
  - Required: out=0 twice, then one packet with weight 6 and payload 60.
  - Afterwards entry 0x12 reads arr=0, acc=0.
- Bypass: the same three packets injected back-to-back from one FIFO -> identical result (weight 6, payload 60).
- Wrap: expect=2, payloads 2**128-1 and 2 -> out payload 1; weights 0xFF and 0x02 -> weight 0x01.
- Stall/reset:
  - out_stall held 5 cycles with 3 packets in flight -> out frozen, in_avail drops as the FIFOs fill, no loss or duplication after release.
  - rst pulsed mid-reduction -> out=0 and the accumulator is cleared.
